// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, common command bytes
// and the frame parity helper, used by both the host transmit and receive paths.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_RESP_ACK    = 8'hFA;

    // PS/2 frames carry odd parity: data bits plus parity hold an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizes the raw PS/2 clock and data lines into the clk domain and
// produces a one-cycle pulse on each falling edge of the synchronized clock.
module ps2_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clrn,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);

    logic [SYNC_STAGES-1:0] clk_pipe;
    logic [SYNC_STAGES-1:0] data_pipe;
    logic                   clk_prev;

    assign clk_sync  = clk_pipe[SYNC_STAGES-1];
    assign data_sync = data_pipe[SYNC_STAGES-1];

    // Idle PS/2 lines float high, so the chain resets to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_pipe  <= '1;
            data_pipe <= '1;
            clk_prev  <= 1'b1;
            clk_fall  <= 1'b0;
        end else begin
            clk_pipe  <= SYNC_STAGES'({clk_pipe, ps2_clk_in});
            data_pipe <= SYNC_STAGES'({data_pipe, ps2_data_in});
            clk_prev  <= clk_sync;
            clk_fall  <= clk_prev & ~clk_sync;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter (inhibit, request-to-send, shift, ACK check).
// Optional feature macro PS2_TX_RETRY_EN: one automatic retry on NACK or timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    import ps2_pkg::*;

    localparam logic [31:0] INHIBIT_LAST = 32'(INHIBIT_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_t state, state_next;
    logic [31:0]   cnt, cnt_next;
    logic [3:0]    bit_cnt, bit_cnt_next;
    logic [8:0]    frame, frame_next;
    logic          drive, drive_next;
    logic          ack, ack_next;
    logic          done_next, err_next;
    logic          fail, timeout;
    logic          clk_sync, data_sync, clk_fall;
`ifdef PS2_TX_RETRY_EN
    logic          retried, retried_next;
`endif

    ps2_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk         (clk),
        .clrn        (clrn),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .clk_sync    (clk_sync),
        .data_sync   (data_sync),
        .clk_fall    (clk_fall)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            frame   <= '0;
            drive   <= 1'b0;
            ack     <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retried <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_cnt <= bit_cnt_next;
            frame   <= frame_next;
            drive   <= drive_next;
            ack     <= ack_next;
            done    <= done_next;
            err     <= err_next;
`ifdef PS2_TX_RETRY_EN
            retried <= retried_next;
`endif
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt + 32'd1;
        bit_cnt_next = bit_cnt;
        frame_next   = frame;
        drive_next   = drive;
        ack_next     = ack;
        done_next    = 1'b0;
        err_next     = 1'b0;
        fail         = 1'b0;
        timeout      = (cnt >= TIMEOUT_LAST);
`ifdef PS2_TX_RETRY_EN
        retried_next = retried;
`endif
        // Only device-generated edges restart the timeout; our own inhibit pulldown must not.
        if (clk_fall && state != ST_IDLE && state != ST_INHIBIT)
            cnt_next = '0;

        case (state)
            ST_IDLE: begin
                cnt_next = '0;
                if (tx_valid) begin
                    frame_next = {odd_parity(tx_data), tx_data};
                    ack_next   = 1'b0;
                    state_next = ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retried_next = 1'b0;
`endif
                end
            end
            ST_INHIBIT: begin
                if (cnt == INHIBIT_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (timeout) begin
                    fail = 1'b1;
                end else if (clk_fall) begin
                    drive_next   = ~frame[0];
                    bit_cnt_next = 4'd1;
                    state_next   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (timeout) begin
                    fail = 1'b1;
                end else if (clk_fall) begin
                    // Edge 10 is the stop bit: leave data released and await the ACK edge.
                    if (bit_cnt == 4'd9) begin
                        drive_next = 1'b0;
                        state_next = ST_ACK;
                    end else begin
                        drive_next   = ~frame[bit_cnt];
                        bit_cnt_next = bit_cnt + 4'd1;
                    end
                end
            end
            ST_ACK: begin
                if (timeout) begin
                    fail = 1'b1;
                end else if (clk_fall) begin
                    ack_next   = ~data_sync;
                    state_next = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (timeout) begin
                    fail = 1'b1;
                end else if (clk_sync && data_sync) begin
                    if (ack) begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (fail) begin
            cnt_next = '0;
`ifdef PS2_TX_RETRY_EN
            if (!retried) begin
                retried_next = 1'b1;
                state_next   = ST_INHIBIT;
            end else begin
                err_next   = 1'b1;
                state_next = ST_IDLE;
            end
`else
            err_next   = 1'b1;
            state_next = ST_IDLE;
`endif
        end
    end

    // Line drives decode straight from registered state so reset releases them at once.
    assign tx_ready    = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign ps2_clk_oe  = (state == ST_INHIBIT);
    assign ps2_data_oe = ((state == ST_INHIBIT) && (cnt == INHIBIT_LAST)) ||
                         (state == ST_REQ) ||
                         ((state == ST_SHIFT) && drive);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a PS/2 device model clocks frames and checks the
// line bits; a monitor checks every done/err pulse against the queued expected outcome.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 300;
    localparam int SYNC = 2;
`ifdef PS2_TX_RETRY_EN
    localparam int TRIES = 2;
`else
    localparam int TRIES = 1;
`endif

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, busy, done, err, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       clk_line, data_line;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int done_cyc = -1;
    int err_cyc = -1;
    logic [1:0]  exp_q[$];
    logic [10:0] frame_q[$];
    logic [1:0]  exp_out;

    assign clk_line  = dev_clk & ~ps2_clk_oe;
    assign data_line = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk         (clk),
        .clrn        (clrn),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .ps2_clk_in  (clk_line),
        .ps2_data_in (data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    // Outcome monitor: every done/err pulse consumes one queued expectation.
    always @(negedge clk) begin
        if (clrn && (done || err)) begin
            if (done) done_cyc = cyc;
            if (err) err_cyc = cyc;
            chk1("done_err_exclusive", done & err, 1'b0);
            if (exp_q.size() == 0) begin
                chk("unexpected_outcome", int'({done, err}), 0);
            end else begin
                exp_out = exp_q.pop_front();
                chk("outcome_done_err", int'({done, err}), int'(exp_out));
            end
        end
    end

    // Device model: waits for a host request, generates nfalls clock pulses sampling
    // data on each rising edge, then (for a full frame) answers ACK or NACK on clock 11.
    task automatic dev_frame(input int nfalls, input logic nack,
                             output int req_cyc, output int inh_len, output int fall5_cyc);
        logic [10:0] got;
        int n;
        got = '0; inh_len = 0; req_cyc = -1; fall5_cyc = -1; n = 0;
        while (!ps2_clk_oe && n < 5000) begin @(negedge clk); n++; end
        if (!ps2_clk_oe) begin
            chk("request_seen", 0, 1);
            return;
        end
        req_cyc = cyc;
        while (ps2_clk_oe && n < 10000) begin @(negedge clk); inh_len++; n++; end
        repeat (4) @(negedge clk);
        got[0] = data_line;
        for (int k = 1; k <= nfalls; k++) begin
            dev_clk = 1'b0;
            if (k == 5) fall5_cyc = cyc;
            repeat (10) @(negedge clk);
            dev_clk = 1'b1;
            if (k <= 10) got[k] = data_line;
            repeat (10) @(negedge clk);
        end
        if (nfalls == 10) begin
            dev_data = nack;
            repeat (2) @(negedge clk);
            dev_clk = 1'b0;
            repeat (10) @(negedge clk);
            dev_clk = 1'b1;
            repeat (5) @(negedge clk);
            dev_data = 1'b1;
            if (frame_q.size() == 0) chk("unexpected_frame", int'(got), -1);
            else chk("frame_bits", int'(got), int'(frame_q.pop_front()));
        end
    endtask

    task automatic send(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk1("accept_busy", busy, 1'b1);
        chk1("accept_clk_oe", ps2_clk_oe, 1'b1);
        chk1("accept_tx_ready", tx_ready, 1'b0);
    endtask

    task automatic wait_ready(input string name, input int limit);
        int n;
        n = 0;
        while (!tx_ready && n < limit) begin @(negedge clk); n++; end
        if (!tx_ready) chk(name, 0, 1);
        @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rq, rq2, inh, f5, d, d1, n;
        repeat (3) @(negedge clk);
        chk1("rst_tx_ready", tx_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_clk_oe", ps2_clk_oe, 1'b0);
        chk1("rst_data_oe", ps2_data_oe, 1'b0);
        clrn = 1'b1;
        repeat (2) @(negedge clk);

        // 0xED, device ACKs: start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
        frame_q.push_back({1'b1, 1'b1, 8'hED, 1'b0});
        exp_q.push_back(2'b10);
        fork
            send(8'hED);
            dev_frame(10, 1'b0, rq, inh, f5);
        join
        wait_ready("ed_ready_timeout", 200);
        chk("ed_inhibit_len", inh, INH);
        chk1("ed_tx_ready_after", tx_ready, 1'b1);

        // 0xF4: five ones, so parity bit is 0.
        frame_q.push_back({1'b1, 1'b0, 8'hF4, 1'b0});
        exp_q.push_back(2'b10);
        fork
            send(8'hF4);
            dev_frame(10, 1'b0, rq, inh, f5);
        join
        wait_ready("f4_ready_timeout", 200);

        // 0xFF with NACK on clock 11.
        for (int t = 0; t < TRIES; t++) frame_q.push_back({1'b1, 1'b1, 8'hFF, 1'b0});
        exp_q.push_back(2'b01);
        fork
            send(8'hFF);
            for (int t = 0; t < TRIES; t++) dev_frame(10, 1'b1, rq, inh, f5);
        join
        wait_ready("nack_ready_timeout", 200);
        chk1("nack_clk_oe", ps2_clk_oe, 1'b0);
        chk1("nack_data_oe", ps2_data_oe, 1'b0);
        chk1("nack_tx_ready", tx_ready, 1'b1);

        // Device stops clocking after edge 5.
        exp_q.push_back(2'b01);
        err_cyc = -1;
        fork
            send(8'hF4);
            begin
                dev_frame(5, 1'b0, rq, inh, f5);
`ifdef PS2_TX_RETRY_EN
                dev_frame(0, 1'b0, rq2, inh, d);
                chk1("retry_second_inhibit", rq2 > 0, 1'b1);
`endif
            end
        join
        wait_ready("timeout_ready_timeout", 3 * TMO);
`ifndef PS2_TX_RETRY_EN
        d = err_cyc - f5;
        chk1("timeout_err_delay", (d >= TMO) && (d <= TMO + 6), 1'b1);
`endif
        chk1("timeout_clk_oe", ps2_clk_oe, 1'b0);
        chk1("timeout_data_oe", ps2_data_oe, 1'b0);

        // Reset mid-SHIFT: after edge 2 the host drives data bit 1 of 0xED (0 -> pulled low).
        fork
            send(8'hED);
            dev_frame(2, 1'b0, rq, inh, f5);
        join
        chk1("pre_reset_data_oe", ps2_data_oe, 1'b1);
        #2;
        clrn = 1'b0;
        #1;
        chk1("async_rst_clk_oe", ps2_clk_oe, 1'b0);
        chk1("async_rst_data_oe", ps2_data_oe, 1'b0);
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        chk1("post_rst_tx_ready", tx_ready, 1'b1);
        chk1("post_rst_busy", busy, 1'b0);

        // Back-to-back with tx_valid held: 0xFF then 0xF4.
        frame_q.push_back({1'b1, 1'b1, 8'hFF, 1'b0});
        frame_q.push_back({1'b1, 1'b0, 8'hF4, 1'b0});
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b10);
        d1 = -1;
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        fork
            begin
                dev_frame(10, 1'b0, rq, inh, f5);
                dev_frame(10, 1'b0, rq2, inh, f5);
            end
            begin
                n = 0;
                while (!busy && n < 100) begin @(negedge clk); n++; end
                tx_data = 8'hF4;
                n = 0;
                while (!done && n < 2000) begin @(negedge clk); n++; end
                d1 = cyc;
                n = 0;
                while (!busy && n < 100) begin @(negedge clk); n++; end
                tx_valid = 1'b0;
            end
        join
        wait_ready("b2b_ready_timeout", 200);
        chk("b2b_second_inhibit_start", rq2, d1 + 1);
        repeat (5) @(negedge clk);
        chk1("b2b_no_third_frame", busy, 1'b0);

        chk("outcome_queue_drained", exp_q.size(), 0);
        chk("frame_queue_drained", frame_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
